// File: rtl/jpeg_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_pkg
// Shared constants and types for the JPEG entropy-coding path.
//   ACC_W   : bit accumulator width of the bit packer
//   CODE_W  : widest Huffman codeword (matches Huffman encoder code_out)
//   LEN_W   : width of the codeword length field
//   MAX_LEN : longest legal codeword; longer lengths are clamped to this
//   pack_state_t : bit packer FSM states
// ---------------------------------------------------------------------------
package jpeg_pkg;

    localparam int ACC_W   = 32;
    localparam int CODE_W  = 20;
    localparam int LEN_W   = 5;
    localparam int MAX_LEN = 20;
    localparam int CNT_W   = 6;   // holds 0..ACC_W

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STUFF = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } pack_state_t;

endpackage

// File: rtl/jpeg_bit_packer.sv
// ---------------------------------------------------------------------------
// jpeg_bit_packer
// Packs right-aligned, MSB-first Huffman codewords into a byte stream,
// inserting a 0x00 after every emitted 0xFF data byte, and on flush pads the
// final partial byte with 1s, drains, and pulses flush_done.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : codeword present
//   in_ready      : codeword accepted this cycle (when in_valid)
//   code_length   : number of valid codeword bits (0..20, larger clamped)
//   code_out      : codeword, right-aligned, MSB first
//   flush         : single-cycle pad-and-drain request
//   out_valid     : out_byte valid
//   out_ready     : downstream accepts byte
//   out_byte      : stream byte
//   flush_done    : one-cycle pulse after a flush has fully drained
//   dbg_state     : current FSM state (pack_state_t encoding)
//
// Handshake: on both interfaces a transfer happens on a rising clock edge
// where valid && ready are both high; out_valid/out_byte never depend on
// out_ready and are held while out_valid && !out_ready.
// ---------------------------------------------------------------------------
module jpeg_bit_packer
    import jpeg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LEN_W-1:0]  code_length,
    input  logic [CODE_W-1:0] code_out,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              flush_done,
    output logic [1:0]        dbg_state
);

    localparam logic [ACC_W-1:0] ACC_ONES = '1;

    pack_state_t       r_state;
    logic              r_ret_flush;   // STUFF returns to FLUSH (else RUN)
    logic              r_flush_held;  // flush seen during STUFF, not yet taken
    logic [ACC_W-1:0]  r_acc;         // valid bits at the top, MSB first
    logic [CNT_W-1:0]  r_cnt;

    logic              w_data_st;
    logic              w_emit;
    logic              w_emit_ff;
    logic              w_stuff_xfer;
    logic              w_accept;
    logic              w_take_flush;
    logic [CNT_W-1:0]  w_len;
    logic [CNT_W-1:0]  w_acc_len;
    logic [ACC_W-1:0]  w_code_ext;
    logic [ACC_W-1:0]  w_acc_sh;
    logic [CNT_W-1:0]  w_cnt_sh;
    logic [CNT_W-1:0]  w_ins_pos;
    logic [ACC_W-1:0]  w_acc_ins;
    logic [CNT_W-1:0]  w_cnt_ins;
    logic [CNT_W-1:0]  w_cnt_pad;
    logic [ACC_W-1:0]  w_pad;
    logic [ACC_W-1:0]  w_acc_nx;
    logic [CNT_W-1:0]  w_cnt_nx;
    pack_state_t       w_state_nx;
    logic              w_ret_nx;
    logic              w_held_nx;

    // Handshake and transfer qualifiers
    assign w_data_st    = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign in_ready     = ((r_state == ST_RUN) || (r_state == ST_STUFF)) &&
                          (r_cnt <= CNT_W'(12)) && !rst;
    assign out_valid    = (r_state == ST_STUFF) || (w_data_st && (r_cnt >= CNT_W'(8)));
    assign out_byte     = (r_state == ST_STUFF) ? 8'h00 : r_acc[ACC_W-1 -: 8];
    assign flush_done   = (r_state == ST_DONE);
    assign dbg_state    = r_state;

    assign w_emit       = w_data_st && (r_cnt >= CNT_W'(8)) && out_ready;
    assign w_emit_ff    = w_emit && (r_acc[ACC_W-1 -: 8] == 8'hFF);
    assign w_stuff_xfer = (r_state == ST_STUFF) && out_ready;
    assign w_accept     = in_valid && in_ready;

    // A flush is taken directly in RUN, or at the end of a stuff byte that
    // returns to RUN (covering one held from earlier STUFF cycles).
    assign w_take_flush = ((r_state == ST_RUN) && flush) ||
                          (w_stuff_xfer && !r_ret_flush && (flush || r_flush_held));

    // Datapath: shift out first, then insert below the post-shift bits.
    assign w_len      = (code_length > LEN_W'(MAX_LEN)) ? CNT_W'(MAX_LEN)
                                                        : {1'b0, code_length};
    assign w_acc_len  = w_accept ? w_len : '0;
    assign w_code_ext = {{(ACC_W-CODE_W){1'b0}}, code_out} & ~(ACC_ONES << w_acc_len);
    assign w_acc_sh   = w_emit ? {r_acc[ACC_W-9:0], 8'h00} : r_acc;
    assign w_cnt_sh   = w_emit ? (r_cnt - CNT_W'(8)) : r_cnt;
    // cnt_sh <= 12 and len <= 20 whenever accepting, so the position never underflows
    assign w_ins_pos  = CNT_W'(ACC_W) - w_cnt_sh - w_acc_len;
    assign w_acc_ins  = w_acc_sh | (w_code_ext << w_ins_pos);
    assign w_cnt_ins  = w_cnt_sh + w_acc_len;

    // Pad: ones from the current bit count up to the next byte boundary
    assign w_cnt_pad  = (w_cnt_ins + CNT_W'(7)) & ~CNT_W'(7);
    assign w_pad      = (ACC_ONES >> w_cnt_ins) & ~(ACC_ONES >> w_cnt_pad);
    assign w_acc_nx   = w_take_flush ? (w_acc_ins | w_pad) : w_acc_ins;
    assign w_cnt_nx   = w_take_flush ? w_cnt_pad : w_cnt_ins;

    always_comb begin
        w_state_nx = r_state;
        w_ret_nx   = r_ret_flush;
        w_held_nx  = r_flush_held;
        case (r_state)
            ST_RUN: begin
                if (w_emit_ff) begin
                    w_state_nx = ST_STUFF;
                    w_ret_nx   = w_take_flush;
                end else if (w_take_flush) begin
                    w_state_nx = ST_FLUSH;
                end
            end
            ST_STUFF: begin
                if (w_stuff_xfer) begin
                    w_held_nx = 1'b0;
                    if (r_ret_flush || w_take_flush) begin
                        w_state_nx = ST_FLUSH;
                    end else begin
                        w_state_nx = ST_RUN;
                    end
                end else if (!r_ret_flush && flush) begin
                    w_held_nx = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (w_emit_ff) begin
                    w_state_nx = ST_STUFF;
                    w_ret_nx   = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nx = ST_DONE;
                end
            end
            default: begin
                w_state_nx = ST_RUN;
                w_ret_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_ret_flush  <= 1'b0;
            r_flush_held <= 1'b0;
            r_acc        <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_ret_flush  <= w_ret_nx;
            r_flush_held <= w_held_nx;
            r_acc        <= w_acc_nx;
            r_cnt        <= w_cnt_nx;
        end
    end

endmodule

// File: doc/jpeg_bit_packer.md
# jpeg_bit_packer

Packs the variable-length Huffman codewords produced by the DC/AC Huffman encoders into a byte-aligned JPEG entropy-coded stream. After every emitted 0xFF data byte it inserts a 0x00 stuff byte. On request it pads the final partial byte with 1s and drains. It sits directly downstream of the Huffman encode stage and feeds the byte-wide output/marker writer.

## Interface
- ACC_W, 32, accumulator width in bits
- CODE_W, 20, maximum codeword width (matches Huffman encoder `code_out`)
- LEN_W, 5, codeword length field width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  codeword present
- in_ready  out  1  packer accepts codeword this cycle
- code_length  in  LEN_W  number of valid bits in code_out, 0..20
- code_out  in  CODE_W  codeword, right-aligned, MSB transmitted first; bits at or above code_length are ignored
- flush  in  1  single-cycle request to pad and drain (end of scan)
- out_valid  out  1  out_byte valid
- out_ready  in  1  downstream accepts byte
- out_byte  out  8  stream byte
- flush_done  out  1  one-cycle pulse when flush has fully drained

## Operation
- State:
  - acc[ACC_W-1:0], MSB-aligned; valid bits occupy acc[31:32-cnt].
  - cnt, 0..32.
  - FSM state ∈ {RUN, STUFF, FLUSH, DONE}.
- Accept:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = (state==RUN || state==STUFF) && cnt<=12 && !rst.
  - Masked code (code_length LSBs) is ORed into acc immediately below the current valid bits.
  - Length 0: accepted, no effect.
  - Length >20 is illegal; it is clamped to 20.
- Emit:
  - out_byte = acc[31:24].
  - In RUN/FLUSH, out_valid = cnt>=8.
  - On out_valid && out_ready: acc <<= 8, cnt -= 8.
- Simultaneous accept and emit in the same cycle:
  - Insertion position uses the post-shift cnt.
  - cnt_next = cnt − 8·emit + len·accept.
- Stuffing:
  - A transferred data byte equal to 0xFF moves RUN→STUFF (or FLUSH→STUFF, remembering the return state).
  - In STUFF: out_valid=1, out_byte=0x00. On transfer, return to the remembered state.
  - No data byte is emitted until the 0x00 is transferred.
- Flush:
  - A flush in RUN is registered. A code accepted in the same cycle is included.
  - Next cycle, enter FLUSH. If cnt mod 8 ≠ 0, the remaining bits of the partial byte are set to 1 and cnt is rounded up to a multiple of 8.
  - In FLUSH, in_ready=0.
  - FLUSH→DONE when cnt==0 and no stuff is pending.
  - DONE: flush_done=1 for one cycle, then RUN.
  - A flush arriving while in STUFF is held and taken on return to RUN.
  - A flush arriving in FLUSH/DONE is ignored.

## Timing
- Reset values: acc=0, cnt=0, state=RUN, out_valid=0, out_byte=0x00, flush_done=0, in_ready=0 while rst is high.
- Latency: a code accepted at edge N appears on out_byte from cycle N+1 once cnt>=8.
- Throughput: one codeword and one byte per cycle.
- out_byte and out_valid are held stable while out_valid && !out_ready.
- Flush with cnt==0: DONE one cycle after entering FLUSH.
- Reset mid-operation:
  - Asynchronous clear of all state.
  - Pending stuff, flush and partial bits are discarded.
  - No flush_done is produced.

## Structure
- Shared package jpeg_pkg holds ACC_W, CODE_W, LEN_W and the packer state enum (RUN, STUFF, FLUSH, DONE). The Huffman encoders use CODE_W/LEN_W from the same package.
- Single module; no sub-module. The insert shifter and FSM are local.

## Test plan
- Reset:
  - Assert rst mid-cycle → all outputs 0 immediately.
  - After release → in_ready=1, out_valid=0.
- Basic pack:
  - (len3, 3'b000) then (len5, 5'b01101) → single byte 0x0D, out_valid the cycle after the second accept.
  - cnt=0 afterwards.
- Stuffing:
  - (len16, 16'hFFA5) → bytes 0xFF, 0x00, 0xA5 on consecutive cycles with out_ready=1.
- Flush pad:
  - (len4, 4'b1010) then flush → byte 0xAF, then flush_done pulse.
  - in_ready=0 throughout FLUSH.
- Backpressure:
  - out_ready=0, accept (len20, 20'h12345) → cnt=20, in_ready=0.
  - out_byte=0x12 held stable.
  - Release → bytes 0x12, 0x34, then in_ready=1 at cnt=4.
- Flush with stuff:
  - (len8, 8'hFF) + flush in the same cycle → 0xFF, 0x00, flush_done.
  - Reset asserted during FLUSH → no flush_done, state RUN.
